// File: rtl/line_burst_sequencer_if.sv
// ============================================================================
// line_burst_sequencer_if : CPU-side and sizing-stage bus bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface line_burst_sequencer_if;
  logic       nTS_CPU;
  logic [1:0] SIZ_CPU;
  logic [3:0] A_CPU;
  logic       RnW_CPU;
  logic       nTA_CPU;
  logic       nTEA_CPU;
  logic       nTS_DS;
  logic [1:0] SIZ_DS;
  logic [3:0] A_DS;
  logic       RnW_DS;
  logic       nTA_DS;
  logic       BUSY;

  // Environment view: the CPU and the downstream sizing stage.
  modport master (
    output nTS_CPU, SIZ_CPU, A_CPU, RnW_CPU, nTA_DS,
    input  nTA_CPU, nTEA_CPU, nTS_DS, SIZ_DS, A_DS, RnW_DS, BUSY
  );

  // Sequencer view.
  modport slave (
    input  nTS_CPU, SIZ_CPU, A_CPU, RnW_CPU, nTA_DS,
    output nTA_CPU, nTEA_CPU, nTS_DS, SIZ_DS, A_DS, RnW_DS, BUSY
  );
endinterface

`default_nettype wire

// File: rtl/line_burst_sequencer.sv
// ============================================================================
// line_burst_sequencer : splits 68040 line transfers into four wrapped longs
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module line_burst_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_WIDTH       = 8
) (
  input  wire logic              BCLK,
  input  wire logic              nRESET,
  line_burst_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [TO_WIDTH-1:0] C_TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_WIDTH-1:0] C_TO_MAX  = TO_WIDTH'(TIMEOUT_CYCLES);

  state_t              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [TO_WIDTH-1:0] wd_q, wd_d;
  logic                line_q, line_d;
  logic [3:0]          a_q, a_d;
  logic [1:0]          siz_q, siz_d;
  logic                rnw_q, rnw_d;
  logic                nts_ds_q, nts_ds_d;
  logic                nta_cpu_q, nta_cpu_d;
  logic                ntea_cpu_q, ntea_cpu_d;
  logic                busy_q, busy_d;

  always_ff @(posedge BCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= S_IDLE;
      beat_q     <= 2'd0;
      wd_q       <= '0;
      line_q     <= 1'b0;
      a_q        <= 4'd0;
      siz_q      <= 2'd0;
      rnw_q      <= 1'b1;
      nts_ds_q   <= 1'b1;
      nta_cpu_q  <= 1'b1;
      ntea_cpu_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wd_q       <= wd_d;
      line_q     <= line_d;
      a_q        <= a_d;
      siz_q      <= siz_d;
      rnw_q      <= rnw_d;
      nts_ds_q   <= nts_ds_d;
      nta_cpu_q  <= nta_cpu_d;
      ntea_cpu_q <= ntea_cpu_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wd_d    = wd_q;
    line_d  = line_q;
    a_d     = a_q;
    siz_d   = siz_q;
    rnw_d   = rnw_q;

    case (state_q)
      S_IDLE: begin
        if (!bus.nTS_CPU) begin
          line_d  = (bus.SIZ_CPU == 2'b11);
          rnw_d   = bus.RnW_CPU;
          beat_d  = 2'd0;
          wd_d    = '0;
          state_d = S_ISSUE;
          if (bus.SIZ_CPU == 2'b11) begin
            siz_d = 2'b00;
            a_d   = {bus.A_CPU[3:2], 2'b00};
          end else begin
            siz_d = bus.SIZ_CPU;
            a_d   = bus.A_CPU;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An acknowledge on the expiry edge takes priority over the error.
        if (!bus.nTA_DS) begin
          state_d = S_ACK;
        end else if (wd_q == C_TO_LAST) begin
          state_d = S_ERR;
        end
        if (wd_q != C_TO_MAX) begin
          wd_d = wd_q + TO_WIDTH'(1);
        end
      end
      S_ACK: begin
        wd_d = '0;
        if (!line_q || beat_q == 2'd3) begin
          state_d = S_IDLE;
        end else begin
          beat_d  = beat_q + 2'd1;
          a_d     = {a_q[3:2] + 2'd1, 2'b00};
          state_d = S_ISSUE;
        end
      end
      S_ERR: begin
        wd_d    = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are registered decodes of the next state so they are glitch free.
  always_comb begin
    nts_ds_d   = (state_d != S_ISSUE);
    nta_cpu_d  = (state_d != S_ACK);
    ntea_cpu_d = (state_d != S_ERR);
    busy_d     = (state_d != S_IDLE);
  end

  assign bus.nTS_DS   = nts_ds_q;
  assign bus.nTA_CPU  = nta_cpu_q;
  assign bus.nTEA_CPU = ntea_cpu_q;
  assign bus.SIZ_DS   = siz_q;
  assign bus.A_DS     = a_q;
  assign bus.RnW_DS   = rnw_q;
  assign bus.BUSY     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_line_burst_sequencer.sv
// ============================================================================
// tb_line_burst_sequencer : directed vector bench with a downstream responder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_burst_sequencer;

  typedef struct {
    string       name;
    logic [1:0]  siz;
    logic [3:0]  a;
    logic        rnw;
    logic [31:0] dly;       // per-beat nTA_DS delay after nTS_DS, 8 bits each, 255 = never
    int          inject;    // loop cycle at which a stray nTS_CPU is driven, 0 = none
    int          exp_ts;
    logic [15:0] exp_a;     // expected A_DS per beat, beat 0 in the low nibble
    logic [1:0]  exp_siz;
    int          exp_ta;
    int          exp_tea;
    int          exp_busy;
  } vec_t;

  logic BCLK = 1'b0;
  logic nRESET;

  line_burst_sequencer_if bus ();

  line_burst_sequencer #(
    .TIMEOUT_CYCLES (4),
    .TO_WIDTH       (8)
  ) dut (
    .BCLK   (BCLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  always #5 BCLK = ~BCLK;

  int          total = 0;
  int          bad   = 0;
  int          ts_cnt, ta_cnt, tea_cnt, busy_cnt, adj_cnt, stab_err, since;
  logic        active, prev_ta;
  logic [3:0]  a_seq [4];
  logic [31:0] beat_delay;
  logic [1:0]  exp_siz;
  logic        exp_rnw;
  vec_t        vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_nTS_DS"},   int'(bus.nTS_DS),   1);
    chk({tag, "_nTA_CPU"},  int'(bus.nTA_CPU),  1);
    chk({tag, "_nTEA_CPU"}, int'(bus.nTEA_CPU), 1);
    chk({tag, "_SIZ_DS"},   int'(bus.SIZ_DS),   0);
    chk({tag, "_A_DS"},     int'(bus.A_DS),     0);
    chk({tag, "_RnW_DS"},   int'(bus.RnW_DS),   1);
    chk({tag, "_BUSY"},     int'(bus.BUSY),     0);
  endtask

  task automatic clear_mon();
    ts_cnt = 0; ta_cnt = 0; tea_cnt = 0; busy_cnt = 0; adj_cnt = 0;
    stab_err = 0; since = 0; active = 1'b0; prev_ta = 1'b0;
    for (int i = 0; i < 4; i++) a_seq[i] = 4'hX;
  endtask

  // One clock: observe outputs just after the edge, then drive the responder.
  task automatic cycle();
    int idx;
    @(posedge BCLK);
    #1;
    if (!bus.nTS_DS) begin
      if (ts_cnt < 4) a_seq[ts_cnt] = bus.A_DS;
      ts_cnt++;
      since  = 0;
      active = 1'b1;
    end else begin
      since++;
    end
    if (!bus.nTA_CPU) begin
      ta_cnt++;
      if (prev_ta) adj_cnt++;
    end
    prev_ta = !bus.nTA_CPU;
    if (!bus.nTEA_CPU) tea_cnt++;
    if (bus.BUSY) begin
      busy_cnt++;
      if (bus.SIZ_DS != exp_siz || bus.RnW_DS != exp_rnw) stab_err++;
    end
    idx = (ts_cnt > 4) ? 3 : ((ts_cnt > 0) ? ts_cnt - 1 : 0);
    bus.nTA_DS = 1'b1;
    if (active && since == int'(beat_delay[8*idx +: 8])) begin
      bus.nTA_DS = 1'b0;
      active     = 1'b0;
    end
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    clear_mon();
    beat_delay  = v.dly;
    exp_siz     = v.exp_siz;
    exp_rnw     = v.rnw;
    bus.SIZ_CPU = v.siz;
    bus.A_CPU   = v.a;
    bus.RnW_CPU = v.rnw;
    bus.nTS_CPU = 1'b0;
    cycle();
    n = 0;
    while (bus.BUSY && n < 60) begin
      bus.nTS_CPU = 1'b1;
      bus.SIZ_CPU = v.siz;
      bus.A_CPU   = v.a;
      bus.RnW_CPU = v.rnw;
      if (v.inject != 0 && n == v.inject) begin
        bus.nTS_CPU = 1'b0;
        bus.SIZ_CPU = 2'b11;
        bus.A_CPU   = 4'hF;
        bus.RnW_CPU = !v.rnw;
      end
      cycle();
      n++;
    end
    bus.nTS_CPU = 1'b1;
    chk({v.name, "_in_time"}, int'(n < 60), 1);
    repeat (3) cycle();
    chk({v.name, "_nts_ds"}, ts_cnt, v.exp_ts);
    for (int i = 0; i < 4; i++) begin
      if (i < v.exp_ts) chk($sformatf("%s_a_ds_beat%0d", v.name, i), int'(a_seq[i]), int'(v.exp_a[4*i +: 4]));
    end
    chk({v.name, "_nta_cpu"},  ta_cnt,   v.exp_ta);
    chk({v.name, "_ntea_cpu"}, tea_cnt,  v.exp_tea);
    chk({v.name, "_busy"},     busy_cnt, v.exp_busy);
    chk({v.name, "_adjacent"}, adj_cnt,  0);
    chk({v.name, "_stable"},   stab_err, 0);
  endtask

  function automatic vec_t mk(input string nm, input logic [1:0] siz, input logic [3:0] a,
                              input logic rnw, input logic [31:0] dly, input int inj,
                              input int ets, input logic [15:0] ea, input logic [1:0] esiz,
                              input int eta, input int etea, input int ebusy);
    vec_t v;
    v.name = nm; v.siz = siz; v.a = a; v.rnw = rnw; v.dly = dly; v.inject = inj;
    v.exp_ts = ets; v.exp_a = ea; v.exp_siz = esiz;
    v.exp_ta = eta; v.exp_tea = etea; v.exp_busy = ebusy;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1, "global time limit");
  end

  initial begin
    int n;
    // Beat cost is ISSUE + delay WAITs + ACK; a timed-out beat is ISSUE + 4 WAITs + ERR.
    vecs[0] = mk("line_rd_0",  2'b11, 4'h0, 1'b1, 32'h02020202, 0, 4, 16'hC840, 2'b00, 4, 0, 16);
    vecs[1] = mk("line_wr_8",  2'b11, 4'h8, 1'b0, 32'h02020202, 0, 4, 16'h40C8, 2'b00, 4, 0, 16);
    vecs[2] = mk("line_rd_7",  2'b11, 4'h7, 1'b1, 32'h01010101, 0, 4, 16'h0C84, 2'b00, 4, 0, 12);
    vecs[3] = mk("word_rd_6",  2'b10, 4'h6, 1'b1, 32'h00000002, 0, 1, 16'h0006, 2'b10, 1, 0, 4);
    vecs[4] = mk("byte_wr_3",  2'b01, 4'h3, 1'b0, 32'h00000001, 1, 1, 16'h0003, 2'b01, 1, 0, 3);
    vecs[5] = mk("long_rd_4",  2'b00, 4'h4, 1'b1, 32'h00000003, 0, 1, 16'h0004, 2'b00, 1, 0, 5);
    vecs[6] = mk("line_tmo",   2'b11, 4'h0, 1'b1, 32'hFFFFFF02, 0, 2, 16'h0040, 2'b00, 1, 1, 10);
    vecs[7] = mk("line_race",  2'b11, 4'h4, 1'b1, 32'h02020402, 0, 4, 16'h0C84, 2'b00, 4, 0, 18);

    nRESET      = 1'b0;
    bus.nTS_CPU = 1'b1;
    bus.SIZ_CPU = 2'b00;
    bus.A_CPU   = 4'h0;
    bus.RnW_CPU = 1'b1;
    bus.nTA_DS  = 1'b1;
    beat_delay  = 32'hFFFFFFFF;
    exp_siz     = 2'b00;
    exp_rnw     = 1'b1;
    clear_mon();
    repeat (3) @(posedge BCLK);
    #1;
    chk_reset("reset");
    nRESET = 1'b1;
    repeat (2) cycle();

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset asserted in the WAIT of the fourth beat aborts without an acknowledge.
    clear_mon();
    beat_delay  = 32'h02020202;
    exp_siz     = 2'b00;
    exp_rnw     = 1'b1;
    bus.SIZ_CPU = 2'b11;
    bus.A_CPU   = 4'h0;
    bus.RnW_CPU = 1'b1;
    bus.nTS_CPU = 1'b0;
    cycle();
    bus.nTS_CPU = 1'b1;
    n = 0;
    while (ts_cnt < 4 && n < 40) begin
      cycle();
      n++;
    end
    chk("rst_mid_reach_beat3", ts_cnt, 4);
    cycle();
    nRESET = 1'b0;
    #1;
    chk_reset("rst_mid");
    chk("rst_mid_nta_before", ta_cnt, 3);
    #2;
    nRESET = 1'b1;
    repeat (4) cycle();
    chk("rst_mid_no_nta_after", ta_cnt, 3);
    chk("rst_mid_no_ntea",      tea_cnt, 0);

    run_txn(mk("long_after_rst", 2'b00, 4'h4, 1'b1, 32'h00000002, 0, 1, 16'h0004, 2'b00, 1, 0, 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
